// File: rtl/mmio_gpio_pkg.sv
// Shared definitions for the MMIO GPIO responder: register offsets,
// responder FSM states, STATUS toggle-count width and a byte-lane merge helper.
package mmio_gpio_pkg;

   localparam int OFF_LED_OUT      = 'h00;
   localparam int OFF_BLINK_PERIOD = 'h04;
   localparam int OFF_CTRL         = 'h08;
   localparam int OFF_STATUS       = 'h0C;

   localparam int STATUS_CNT_W = 16;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } state_t;

   // Replace only the byte lanes of old_val whose strobe bit is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      merge_bytes = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            merge_bytes[i*8 +: 8] = new_val[i*8 +: 8];
         end
      end
   endfunction

endpackage

// File: rtl/mmio_gpio_resp_if.sv
// Request/response bus between the core (master) and the GPIO responder (slave).
interface mmio_gpio_resp_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mmio_gpio_blink.sv
// Blink timer: free-running period counter that toggles blink_q and bumps a
// wrapping toggle count every BLINK_PERIOD cycles while enabled.
module mmio_gpio_blink
   import mmio_gpio_pkg::*;
#(
   parameter int PERIOD_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    blink_en,
   input  logic [PERIOD_W-1:0]     period,
   input  logic                    clear,
   output logic                    blink_q,
   output logic [STATUS_CNT_W-1:0] toggle_cnt
);

   logic [PERIOD_W-1:0] count;

   // Counter runs only with a non-zero period; a config write restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         blink_q    <= 1'b0;
         toggle_cnt <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (blink_en && (period != '0)) begin
         if (count == period - PERIOD_W'(1)) begin
            count      <= '0;
            blink_q    <= ~blink_q;
            toggle_cnt <= toggle_cnt + STATUS_CNT_W'(1);
         end else begin
            count <= count + PERIOD_W'(1);
         end
      end else begin
         count <= '0;
      end
   end

endmodule

// File: rtl/mmio_gpio_resp.sv
// MMIO GPIO responder: single-outstanding load/store slave driving one LED.
// Define MMIO_GPIO_BLINK_EN to add BLINK_PERIOD, CTRL, STATUS and the blink
// timer; without it only LED_OUT is mapped.
module mmio_gpio_resp
   import mmio_gpio_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int PERIOD_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   mmio_gpio_resp_if.slave  bus,
   output logic             led
);

   state_t            state;
   logic              led_out;
   logic [ADDR_W-1:0] word_addr;
   logic              accept;
   logic              hit_led, hit_period, hit_ctrl, hit_status;
   logic              wr_led;
   logic [31:0]       rd_period, rd_ctrl, rd_status;
   logic [31:0]       rd_data;
   logic              rd_err;
   logic              led_src;
   logic              unused_bits;

   assign word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
   assign accept    = bus.req_valid && bus.req_ready;
   assign hit_led   = (word_addr == ADDR_W'(OFF_LED_OUT));
   assign wr_led    = accept && bus.req_we && hit_led;

`ifdef MMIO_GPIO_BLINK_EN
   logic [PERIOD_W-1:0]     blink_period;
   logic                    blink_en;
   logic                    blink_q;
   logic [STATUS_CNT_W-1:0] toggle_cnt;
   logic [31:0]             period_merged;
   logic                    wr_period, wr_ctrl, cfg_write;
   logic                    unused_period_bits;

   assign hit_period    = (word_addr == ADDR_W'(OFF_BLINK_PERIOD));
   assign hit_ctrl      = (word_addr == ADDR_W'(OFF_CTRL));
   assign hit_status    = (word_addr == ADDR_W'(OFF_STATUS));
   assign wr_period     = accept && bus.req_we && hit_period;
   assign wr_ctrl       = accept && bus.req_we && hit_ctrl;
   assign cfg_write     = (wr_period || wr_ctrl) && (|bus.req_wstrb);
   assign period_merged = merge_bytes(32'(blink_period), bus.req_wdata, bus.req_wstrb);
   assign rd_period     = 32'(blink_period);
   assign rd_ctrl       = {31'b0, blink_en};
   assign rd_status     = 32'(toggle_cnt);
   assign led_src       = blink_en ? blink_q : led_out;
   assign unused_period_bits = ^period_merged;

   // Blink configuration registers, updated on the acceptance edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_period <= '0;
         blink_en     <= 1'b0;
      end else begin
         if (wr_period) begin
            blink_period <= period_merged[PERIOD_W-1:0];
         end
         if (wr_ctrl && bus.req_wstrb[0]) begin
            blink_en <= bus.req_wdata[0];
         end
      end
   end

   mmio_gpio_blink #(
      .PERIOD_W(PERIOD_W)
   ) u_blink (
      .clk       (clk),
      .rst       (rst),
      .blink_en  (blink_en),
      .period    (blink_period),
      .clear     (cfg_write),
      .blink_q   (blink_q),
      .toggle_cnt(toggle_cnt)
   );
`else
   localparam int unused_period_w = PERIOD_W;

   assign hit_period = 1'b0;
   assign hit_ctrl   = 1'b0;
   assign hit_status = 1'b0;
   assign rd_period  = '0;
   assign rd_ctrl    = '0;
   assign rd_status  = '0;
   assign led_src    = led_out;
`endif

   assign unused_bits = ^{bus.req_addr[1:0], bus.req_wdata, bus.req_wstrb};

   assign rd_err = !(hit_led || hit_period || hit_ctrl || hit_status)
                   || (bus.req_we && hit_status);

   // Load data for the addressed register; stores and unmapped offsets read 0.
   always_comb begin
      rd_data = '0;
      if (!bus.req_we) begin
         if (hit_led) begin
            rd_data = {31'b0, led_out};
         end else if (hit_period) begin
            rd_data = rd_period;
         end else if (hit_ctrl) begin
            rd_data = rd_ctrl;
         end else if (hit_status) begin
            rd_data = rd_status;
         end
      end
   end

   // LED_OUT register, only lane 0 carries state.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_out <= 1'b0;
      end else if (wr_led && bus.req_wstrb[0]) begin
         led_out <= bus.req_wdata[0];
      end
   end

   // LED pin is a registered copy of the selected source.
   always_ff @(posedge clk) begin
      if (rst) begin
         led <= 1'b0;
      end else begin
         led <= led_src;
      end
   end

   // Responder FSM: accept one request, then hold the response until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.req_ready <= 1'b1;
               if (accept) begin
                  state         <= ST_RESP;
                  bus.req_ready <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= rd_data;
                  bus.rsp_err   <= rd_err;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  state         <= ST_IDLE;
                  bus.req_ready <= 1'b1;
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
